// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage constants: FSM state codes, default widths and the NOP encoding.
package fetch_ctrl_pkg;

    localparam int unsigned DEFAULT_PC_W      = 32;
    localparam int unsigned PC_STEP           = 4;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 3'd0;
    localparam fetch_state_t REQ   = 3'd1;
    localparam fetch_state_t WAIT  = 3'd2;
    localparam fetch_state_t HOLD  = 3'd3;
    localparam fetch_state_t DRAIN = 3'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction memory, decode handshake, BPU and trap/stall inputs.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = DEFAULT_PC_W
) ();

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcplf;
    logic            pc_en;
    logic            bpu_mux_sel;
    logic [PC_W-1:0] bpu_npc;
    logic            trap_req;
    logic [PC_W-1:0] trap_vec;
    logic            stall;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pcplf, pc_en,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               bpu_mux_sel, bpu_npc, trap_req, trap_vec, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pcplf, pc_en,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               bpu_mux_sel, bpu_npc, trap_req, trap_vec, stall
    );

endinterface

// File: rtl/fetch_redirect_arb.sv
// Next-PC priority pick: trap vector, then BPU target, then the sequential PC.
module fetch_redirect_arb
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = DEFAULT_PC_W
) (
    input  logic            trap_req,
    input  logic [PC_W-1:0] trap_vec,
    input  logic            bpu_mux_sel,
    input  logic [PC_W-1:0] bpu_npc,
    input  logic [PC_W-1:0] seq_pc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_target
);

    always_comb begin
        redirect_valid = trap_req || bpu_mux_sel;
        if (trap_req) begin
            redirect_target = trap_vec;
        end else if (bpu_mux_sel) begin
            redirect_target = bpu_npc;
        end else begin
            redirect_target = seq_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: single-outstanding imem fetch, decode handshake, redirect/squash handling.
// Optional perf counters (redirect_cnt, squash_cnt) under `FETCH_PERF_CNT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W      = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        nrst,
    fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] squash_cnt
`endif
);

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] redirect_target;
    logic [31:0]     instr_q;
    logic            squash_q;
    logic            redirect_valid;
    logic            req;
    logic            granted;
    logic            rvalid;
    logic            instr_valid;
    logic            pc_en;

    assign req         = (state == REQ) && !bus.stall;
    assign granted     = req && bus.imem_gnt;
    assign rvalid      = bus.imem_rvalid;
    assign instr_valid = (state == HOLD);
    assign pc_en       = instr_valid && bus.instr_ready;
    assign seq_pc      = pc_q + PC_W'(PC_STEP);

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc_q;
    assign bus.pcplf       = seq_pc;
    assign bus.pc_en       = pc_en;

    fetch_redirect_arb #(
        .PC_W (PC_W)
    ) u_arb (
        .trap_req        (bus.trap_req),
        .trap_vec        (bus.trap_vec),
        .bpu_mux_sel     (bus.bpu_mux_sel),
        .bpu_npc         (bus.bpu_npc),
        .seq_pc          (seq_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            redirect_pc <= '0;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            squash_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fetch_pc <= RESET_PC;
                    state    <= REQ;
                end
                REQ: begin
                    // A grant coinciding with a redirect leaves a wrong-path response to drain.
                    if (granted && redirect_valid) begin
                        redirect_pc <= redirect_target;
                        state       <= DRAIN;
                    end else if (granted) begin
                        state <= WAIT;
                    end else if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end
                end
                WAIT: begin
                    if (rvalid && redirect_valid) begin
                        fetch_pc <= redirect_target;
                        state    <= REQ;
                    end else if (redirect_valid) begin
                        redirect_pc <= redirect_target;
                        state       <= DRAIN;
                    end else if (rvalid) begin
                        instr_q <= bus.imem_rdata;
                        pc_q    <= fetch_pc;
                        state   <= HOLD;
                    end
                end
                DRAIN: begin
                    if (rvalid) begin
                        fetch_pc <= redirect_valid ? redirect_target : redirect_pc;
                        state    <= REQ;
                    end else if (redirect_valid) begin
                        redirect_pc <= redirect_target;
                    end
                end
                HOLD: begin
                    // A squashed NOP resumes at the saved target unless a newer redirect arrives.
                    if (pc_en) begin
                        fetch_pc <= (squash_q && !redirect_valid) ? redirect_pc : redirect_target;
                        squash_q <= 1'b0;
                        state    <= REQ;
                    end else if (redirect_valid) begin
                        redirect_pc <= redirect_target;
                        instr_q     <= NOP_INSTR;
                        squash_q    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic redirect_evt;
    logic squash_evt;

    assign redirect_evt = redirect_valid && (state != IDLE);
    assign squash_evt   = ((state == DRAIN) && rvalid)
                       || ((state == WAIT) && rvalid && redirect_valid)
                       || ((state == HOLD) && !pc_en && redirect_valid && !squash_q);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            redirect_cnt <= '0;
            squash_cnt   <= '0;
        end else begin
            if (redirect_evt && (redirect_cnt != '1)) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            if (squash_evt && (squash_cnt != '1)) begin
                squash_cnt <= squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: accept-cycle redirect table plus hand-written redirect/stall/reset sequences.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.PC_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt;
    logic [31:0] squash_cnt;
`endif

    fetch_ctrl #(
        .PC_W      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_cnt (redirect_cnt),
        .squash_cnt   (squash_cnt)
`endif
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        trap;
        logic [31:0] trap_vec;
        logic        bpu;
        logic [31:0] bpu_npc;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[5];

    int tests = 0;
    int fails = 0;
    int exp_redirect = 0;
    int exp_squash = 0;

    // memory responder state
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // One clock: sample the request, cross the edge, then update the memory model at negedge.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        fire = bus.imem_req && bus.imem_gnt;
        a    = bus.imem_addr;
        @(posedge clk);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        if (fire) begin
            pend      = 1'b1;
            pend_addr = a;
            cnt       = lat;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word(pend_addr);
                pend            = 1'b0;
            end
        end
    endtask

    task automatic wait_hold(input string name, input logic [31:0] exp_pc);
        logic found;
        found = 1'b0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_valid"}, 32'(found), 32'd1);
        if (found) begin
            check({name, "_pc"}, bus.pc, exp_pc);
            check({name, "_pcplf"}, bus.pcplf, exp_pc + 32'd4);
            check({name, "_instr"}, bus.instr, word(exp_pc));
        end
    endtask

    task automatic accept(input logic trap, input logic [31:0] tv, input logic bpu, input logic [31:0] npc);
        bus.trap_req    = trap;
        bus.trap_vec    = tv;
        bus.bpu_mux_sel = bpu;
        bus.bpu_npc     = npc;
        bus.instr_ready = 1'b1;
        #1;
        check("accept_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        bus.trap_req    = 1'b0;
        bus.bpu_mux_sel = 1'b0;
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   stale;

        vecs[0] = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   32'h4};
        vecs[1] = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h4,   32'h8};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 32'h100, 32'h8,   32'h100};
        vecs[3] = '{1'b1, 32'h80, 1'b1, 32'h300, 32'h100, 32'h80};
        vecs[4] = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h80,  32'h84};

        nrst            = 1'b0;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.bpu_mux_sel = 1'b0;
        bus.bpu_npc     = '0;
        bus.trap_req    = 1'b0;
        bus.trap_vec    = '0;
        bus.stall       = 1'b0;
        tick();
        tick();

        bus.instr_ready = 1'b1;
        #1;
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_instr", bus.instr, NOP);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_pcplf", bus.pcplf, 32'h4);
        check("rst_pc_en", 32'(bus.pc_en), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_redirect_cnt", redirect_cnt, 32'd0);
        check("rst_squash_cnt", squash_cnt, 32'd0);
`endif
        bus.instr_ready = 1'b0;
        nrst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            wait_hold($sformatf("vec%0d", v), vecs[v].exp_pc);
            check($sformatf("vec%0d_pc_en_idle", v), 32'(bus.pc_en), 32'd0);
            accept(vecs[v].trap, vecs[v].trap_vec, vecs[v].bpu, vecs[v].bpu_npc);
            if (vecs[v].trap || vecs[v].bpu) exp_redirect++;
            check($sformatf("vec%0d_valid_drop", v), 32'(bus.instr_valid), 32'd0);
            check($sformatf("vec%0d_req", v), 32'(bus.imem_req), 32'd1);
            check($sformatf("vec%0d_next_addr", v), bus.imem_addr, vecs[v].exp_next);
        end

        // BPU redirect while a slow response is outstanding: drained, never shown to decode
        lat = 3;
        tick();
        check("wait_req_low", 32'(bus.imem_req), 32'd0);
        bus.bpu_mux_sel = 1'b1;
        bus.bpu_npc     = 32'h200;
        tick();
        bus.bpu_mux_sel = 1'b0;
        exp_redirect++;
        exp_squash++;
        lat = 1;
        bus.instr_ready = 1'b1;
        found = 1'b0;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req) begin
                found = 1'b1;
                break;
            end
            if (bus.instr_valid) stale++;
            tick();
        end
        bus.instr_ready = 1'b0;
        check("drain_req_seen", 32'(found), 32'd1);
        check("drain_stale_valid", 32'(stale), 32'd0);
        check("drain_addr", bus.imem_addr, 32'h200);
        wait_hold("after_drain", 32'h200);

        // Trap and BPU together in HOLD outside the accept cycle: one NOP, then trap vector
        bus.trap_req    = 1'b1;
        bus.trap_vec    = 32'h80;
        bus.bpu_mux_sel = 1'b1;
        bus.bpu_npc     = 32'h200;
        tick();
        bus.trap_req    = 1'b0;
        bus.bpu_mux_sel = 1'b0;
        exp_redirect++;
        exp_squash++;
        check("squash_valid", 32'(bus.instr_valid), 32'd1);
        check("squash_instr", bus.instr, NOP);
        accept(1'b0, 32'h0, 1'b0, 32'h0);
        check("squash_once", 32'(bus.instr_valid), 32'd0);
        check("trap_addr", bus.imem_addr, 32'h80);
        wait_hold("trap_fetch", 32'h80);

        // Stall held for five cycles in REQ
        bus.stall = 1'b1;
        accept(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_req", i), 32'(bus.imem_req), 32'd0);
            check($sformatf("stall%0d_addr", i), bus.imem_addr, 32'h84);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        check("unstall_req", 32'(bus.imem_req), 32'd1);
        check("unstall_addr", bus.imem_addr, 32'h84);
        wait_hold("after_stall", 32'h84);
`ifdef FETCH_PERF_CNT_EN
        check("redirect_cnt", redirect_cnt, 32'(exp_redirect));
        check("squash_cnt", squash_cnt, 32'(exp_squash));
`endif

        // Sequential wrap at the top of the address space
        accept(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        exp_redirect++;
        check("wrap_target", bus.imem_addr, 32'hFFFF_FFFC);
        wait_hold("wrap_top", 32'hFFFF_FFFC);
        accept(1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_next", bus.imem_addr, 32'h0);
        wait_hold("wrap_zero", 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("redirect_cnt_wrap", redirect_cnt, 32'(exp_redirect));
`endif
        accept(1'b0, 32'h0, 1'b0, 32'h0);
        check("pre_reset_addr", bus.imem_addr, 32'h4);

        // Reset with a response in flight: the late rvalid must be ignored
        lat = 3;
        tick();
        nrst = 1'b0;
        tick();
        check("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("mid_rst_pc", bus.pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("mid_rst_redirect_cnt", redirect_cnt, 32'd0);
        check("mid_rst_squash_cnt", squash_cnt, 32'd0);
`endif
        nrst = 1'b1;
        lat = 1;
        tick();
        check("post_rst_stale_rvalid", 32'(bus.imem_rvalid), 32'd1);
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, 32'h0);
        wait_hold("post_rst", 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
